// File: rtl/alsu_arbiter.sv
// alsu_arbiter: shares one ALSU between two requesters.
// Round-robin grant with an optional per-requester grant lock (bounded by
// LOCK_MAX), one registered command per cycle into the ALSU, and a
// latency-matched tag pipe that routes each result back to its owner with
// an invalid-command flag.
// Optional per-requester statistics counters are built only when the macro
// ALSU_ARB_STATS_EN is defined; otherwise stat_issued/stat_err read 0.
module alsu_arbiter #(
  parameter int LATENCY  = 2,
  parameter int LOCK_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req0_lock,
  input  logic [15:0] req0_cmd,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic        req1_lock,
  input  logic [15:0] req1_cmd,
  output logic        req1_ready,
  output logic [15:0] alsu_cmd,
  input  logic [5:0]  alsu_out,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [5:0]  rsp_data,
  output logic        rsp_err,
  output logic [31:0] stat_issued,
  output logic [31:0] stat_err
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // One in-flight command: who owns it and whether the ALSU will reject it.
  typedef struct packed {
    logic vld;
    logic id;
    logic err;
  } tag_t;

  state_t                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic [CNT_W-1:0]       lock_cnt_q, lock_cnt_d;
  logic                   last_grant_q, last_grant_d;
  logic [15:0]            alsu_cmd_q, alsu_cmd_d;
  tag_t                   issue_tag_q, issue_tag_d;
  tag_t [LATENCY-1:0]     pipe_q, pipe_d;

  logic                   grant;
  logic                   accept;
  logic                   acc_lock;
  logic [15:0]            acc_cmd;
  logic                   acc_err;
  tag_t                   out_tag;

  // Grant selection: lock owner first, then a lone requester, then round-robin.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant = ~last_grant_q;
    if (state_q == ST_LOCKED) begin
      grant = owner_q;
    end else if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = ~grant;
  assign req1_ready = grant;

  assign accept   = grant ? req1_valid : req0_valid;
  assign acc_lock = grant ? req1_lock  : req0_lock;
  assign acc_cmd  = grant ? req1_cmd   : req0_cmd;

  // Invalid unless bypassed: reduction on a non-logic opcode, or opcode 6/7.
  assign acc_err = ~acc_cmd[14] & ~acc_cmd[15] &
                   (((acc_cmd[12] | acc_cmd[13]) & (acc_cmd[7] | acc_cmd[8])) |
                    (acc_cmd[8] & acc_cmd[7]));

  // Next-state for command issue, tag pipe, round-robin pointer and lock FSM.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lock_cnt_d   = lock_cnt_q;
    last_grant_d = last_grant_q;
    alsu_cmd_d   = 16'h0000;
    issue_tag_d  = '0;

    if (accept) begin
      alsu_cmd_d   = acc_cmd;
      issue_tag_d  = '{vld: 1'b1, id: grant, err: acc_err};
      last_grant_d = grant;
    end

    pipe_d[0] = issue_tag_q;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    if (state_q == ST_OPEN) begin
      if (accept && acc_lock && (LOCK_MAX > 1)) begin
        state_d    = ST_LOCKED;
        owner_d    = grant;
        lock_cnt_d = CNT_W'(1);
      end
    end else begin
      if (!accept || !acc_lock) begin
        state_d    = ST_OPEN;
        lock_cnt_d = '0;
      end else if (lock_cnt_q == CNT_W'(LOCK_MAX - 1)) begin
        // Forced release: owner is the last grant, so the rival wins next contest.
        state_d      = ST_OPEN;
        lock_cnt_d   = '0;
        last_grant_d = owner_q;
      end else begin
        lock_cnt_d = lock_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset drops every in-flight tag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q      <= ST_OPEN;
      owner_q      <= 1'b0;
      lock_cnt_q   <= '0;
      last_grant_q <= 1'b1;
      alsu_cmd_q   <= 16'h0000;
      issue_tag_q  <= '0;
      // NOTE: the tag pipe is reset because its valid bits are control state, not bulk data storage.
      pipe_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lock_cnt_q   <= lock_cnt_d;
      last_grant_q <= last_grant_d;
      alsu_cmd_q   <= alsu_cmd_d;
      issue_tag_q  <= issue_tag_d;
      pipe_q       <= pipe_d;
    end
  end

  assign alsu_cmd  = alsu_cmd_q;
  assign out_tag   = pipe_q[LATENCY-1];
  assign rsp_valid = out_tag.vld;
  assign rsp_id    = out_tag.id;
  assign rsp_err   = out_tag.err;
  assign rsp_data  = out_tag.vld ? alsu_out : 6'd0;

`ifdef ALSU_ARB_STATS_EN
  logic [1:0][15:0] issued_q, issued_d;
  logic [1:0][15:0] errcnt_q, errcnt_d;

  // Saturating per-requester counters: accepts, and responses flagged invalid.
  always_comb begin
    issued_d = issued_q;
    errcnt_d = errcnt_q;
    if (accept && (issued_q[grant] != 16'hFFFF)) begin
      issued_d[grant] = issued_q[grant] + 16'd1;
    end
    if (out_tag.vld && out_tag.err && (errcnt_q[out_tag.id] != 16'hFFFF)) begin
      errcnt_d[out_tag.id] = errcnt_q[out_tag.id] + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q <= '0;
      errcnt_q <= '0;
    end else begin
      issued_q <= issued_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign stat_issued = issued_q;
  assign stat_err    = errcnt_q;
`else
  assign stat_issued = 32'd0;
  assign stat_err    = 32'd0;
`endif

endmodule

// File: tb/tb_alsu_arbiter.sv
// tb_alsu_arbiter: self-checking bench for alsu_arbiter.
// Contains a behavioural ALSU (input register + output register) as the
// environment, and a cycle-level reference of the arbitration rules that
// evaluates the issued command stream sequentially to predict results.
module tb_alsu_arbiter;

  localparam int LAT      = 2;
  localparam int LOCK_MAX = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req0_lock = 1'b0;
  logic [15:0] req0_cmd = 16'h0;
  logic        req0_ready;
  logic        req1_valid = 1'b0, req1_lock = 1'b0;
  logic [15:0] req1_cmd = 16'h0;
  logic        req1_ready;
  logic [15:0] alsu_cmd;
  logic [5:0]  alsu_out;
  logic        rsp_valid, rsp_id, rsp_err;
  logic [5:0]  rsp_data;
  logic [31:0] stat_issued, stat_err;

  int checks = 0;
  int errors = 0;

  alsu_arbiter #(.LATENCY(LAT), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_lock(req0_lock), .req0_cmd(req0_cmd), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_lock(req1_lock), .req1_cmd(req1_cmd), .req1_ready(req1_ready),
    .alsu_cmd(alsu_cmd), .alsu_out(alsu_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .stat_issued(stat_issued), .stat_err(stat_err)
  );

  always #5 clk = ~clk;

  // Command is rejected by the ALSU when not bypassed and either opcode is
  // 6/7 or a reduction is requested on anything but AND/XOR.
  function automatic bit is_invalid(input logic [15:0] c);
    int op;
    op = int'(c[8:6]);
    if (c[14] || c[15]) return 1'b0;
    return (op >= 6) || ((c[12] || c[13]) && op >= 2);
  endfunction

  // Result of one ALSU command given the previous ALSU output.
  function automatic logic [5:0] alsu_eval(input logic [15:0] c, input logic [5:0] prev);
    logic [2:0] a, b;
    a = c[5:3];
    b = c[2:0];
    if (c[14]) return {3'b000, a};
    if (c[15]) return {3'b000, b};
    if (is_invalid(c)) return 6'd0;
    case (int'(c[8:6]))
      0: return c[12] ? {5'd0, &a} : c[13] ? {5'd0, &b} : {3'b000, a & b};
      1: return c[12] ? {5'd0, ^a} : c[13] ? {5'd0, ^b} : {3'b000, a ^ b};
      2: return 6'(int'(a) + int'(b) + int'(c[11]));
      3: return 6'(int'(a) * int'(b));
      4: return c[10] ? {prev[4:0], c[9]} : {c[9], prev[5:1]};
      5: return c[10] ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
      default: return 6'd0;
    endcase
  endfunction

  // Environment: ALSU with input and output registers.
  logic [15:0] alsu_in_q;
  logic [5:0]  alsu_out_q;
  always @(posedge clk) begin
    if (rst) begin
      alsu_in_q  <= 16'h0;
      alsu_out_q <= 6'd0;
    end else begin
      alsu_in_q  <= alsu_cmd;
      alsu_out_q <= alsu_eval(alsu_in_q, alsu_out_q);
    end
  end
  assign alsu_out = alsu_out_q;

  // Reference state.
  int         m_own;       // -1: no lock holder
  int         m_cnt;
  int         m_last;
  logic [5:0] m_prev;
  int         m_iss[2];
  int         m_errc[2];
  bit         s_v[8];
  bit         s_id[8];
  bit         s_err[8];
  logic [5:0] s_data[8];
  int         cyc = 0;

  // Last-sampled DUT outputs and the comparison vectors.
  logic        o_r0, o_r1, o_v, o_id, o_err;
  logic [5:0]  o_data;
  logic [74:0] obs_vec, exp_vec;

  task automatic model_reset();
    m_own = -1; m_cnt = 0; m_last = 1; m_prev = 6'd0;
    for (int i = 0; i < 2; i++) begin m_iss[i] = 0; m_errc[i] = 0; end
    for (int i = 0; i < 8; i++) begin s_v[i] = 0; s_id[i] = 0; s_err[i] = 0; s_data[i] = 6'd0; end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_lock = 1'b0; req1_lock = 1'b0;
    repeat (cycles) begin @(posedge clk); #1; end
    rst = 1'b0;
    model_reset();
  endtask

  // Drive one cycle, sample outputs mid-cycle, advance the reference.
  task automatic run_cycle(input logic v0, input logic l0, input logic [15:0] c0,
                           input logic v1, input logic l1, input logic [15:0] c1);
    int g, slot, ns;
    bit acc, lk;
    logic [15:0] cmd;
    logic [63:0] e_stats;
    req0_valid = v0; req0_lock = l0; req0_cmd = c0;
    req1_valid = v1; req1_lock = l1; req1_cmd = c1;
    @(negedge clk);
    o_r0 = req0_ready; o_r1 = req1_ready; o_v = rsp_valid;
    o_id = rsp_id; o_err = rsp_err; o_data = rsp_data;

    if (m_own >= 0)        g = m_own;
    else if (v0 && !v1)    g = 0;
    else if (v1 && !v0)    g = 1;
    else                   g = 1 - m_last;
    acc = (g == 0) ? v0 : v1;
    lk  = (g == 0) ? l0 : l1;
    cmd = (g == 0) ? c0 : c1;
    slot = cyc % 8;

`ifdef ALSU_ARB_STATS_EN
    e_stats = {16'(m_iss[1]), 16'(m_iss[0]), 16'(m_errc[1]), 16'(m_errc[0])};
`else
    e_stats = 64'd0;
`endif
    exp_vec = {g == 0, g == 1, s_v[slot], s_v[slot] & s_id[slot], s_v[slot] & s_err[slot],
               s_v[slot] ? s_data[slot] : 6'd0, e_stats};
    obs_vec = {o_r0, o_r1, o_v, s_v[slot] ? o_id : 1'b0, s_v[slot] ? o_err : 1'b0,
               o_data, stat_issued, stat_err};

    if (s_v[slot] && s_err[slot] && m_errc[s_id[slot]] < 65535) m_errc[s_id[slot]]++;
    if (acc && m_iss[g] < 65535) m_iss[g]++;
    m_prev = alsu_eval(acc ? cmd : 16'h0000, m_prev);
    ns = (cyc + 1 + LAT) % 8;
    s_v[ns] = acc; s_id[ns] = g[0]; s_err[ns] = acc && is_invalid(cmd); s_data[ns] = m_prev;

    if (m_own < 0) begin
      if (acc && lk && LOCK_MAX > 1) begin m_own = g; m_cnt = 1; end
    end else if (!acc || !lk) begin
      m_own = -1;
    end else begin
      m_cnt++;
      if (m_cnt >= LOCK_MAX) m_own = -1;
    end
    if (acc) m_last = g;

    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic test_reset();
    do_reset(3);
    checks++;
    if (alsu_cmd !== 16'h0 || rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: alsu_cmd=%h rsp_valid=%b rsp_id=%b rsp_err=%b, want 0", alsu_cmd, rsp_valid, rsp_id, rsp_err);
    end
    checks++;
    if (stat_issued !== 32'd0 || stat_err !== 32'd0) begin
      errors++;
      $display("FAIL reset_stats: issued=%h err=%h, want 0", stat_issued, stat_err);
    end
    run_cycle(1, 0, 16'h0000, 1, 0, 16'h0000);
    checks++;
    if (obs_vec !== exp_vec) begin errors++; $display("FAIL reset_first cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
    checks++;
    if (o_r0 !== 1'b1) begin errors++; $display("FAIL reset_first_winner: req0_ready=%b, want 1", o_r0); end
  endtask

  task automatic test_single_add();
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      run_cycle(i == 0, 0, (i == 0) ? 16'h089D : 16'h0, 0, 0, 16'h0);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL add_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
      if (i == 0) begin
        checks++;
        if (alsu_cmd !== 16'h089D) begin errors++; $display("FAIL add_issue: alsu_cmd=%h, want 089d", alsu_cmd); end
      end
      if (i == 3) begin
        checks++;
        if (o_v !== 1'b1 || o_id !== 1'b0 || o_data !== 6'd9 || o_err !== 1'b0) begin
          errors++;
          $display("FAIL add_rsp: valid=%b id=%b data=%0d err=%b, want 1 0 9 0", o_v, o_id, o_data, o_err);
        end
      end
    end
  endtask

  task automatic test_alternate();
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      if (i < 12) run_cycle(1, 0, 16'($urandom), 1, 0, 16'($urandom));
      else        run_cycle(0, 0, 16'h0, 0, 0, 16'h0);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL alt_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
      if (i < 8) begin
        checks++;
        if (o_r0 !== ((i % 2) == 0)) begin errors++; $display("FAIL alt_grant i=%0d: req0_ready=%b, want %0d", i, o_r0, (i % 2) == 0); end
      end
      if (i >= 3 && i < 11) begin
        checks++;
        if (o_v !== 1'b1 || o_id !== ((i - 3) % 2 == 1)) begin
          errors++; $display("FAIL alt_rsp i=%0d: valid=%b id=%b, want 1 %0d", i, o_v, o_id, (i - 3) % 2);
        end
      end
    end
  endtask

  task automatic test_lock_chain();
    logic [15:0] other;
    other = 16'h00D1;
    do_reset(1);
    for (int i = 0; i < 7; i++) begin
      case (i)
        0:       run_cycle(1, 1, 16'h00FF, 1, 0, other);
        1:       run_cycle(1, 0, 16'h0700, 1, 0, other);
        2:       run_cycle(0, 0, 16'h0,    1, 0, other);
        default: run_cycle(0, 0, 16'h0,    0, 0, 16'h0);
      endcase
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL lock_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
      if (i < 3) begin
        checks++;
        if (o_r1 !== (i == 2)) begin errors++; $display("FAIL lock_block i=%0d: req1_ready=%b, want %0d", i, o_r1, i == 2); end
      end
      if (i == 3 || i == 4) begin
        checks++;
        if (o_v !== 1'b1 || o_id !== 1'b0 || o_data !== ((i == 3) ? 6'd49 : 6'd35)) begin
          errors++; $display("FAIL lock_chain i=%0d: valid=%b id=%b data=%0d, want 1 0 %0d", i, o_v, o_id, o_data, (i == 3) ? 49 : 35);
        end
      end
    end
  endtask

  task automatic test_lock_max();
    do_reset(1);
    for (int i = 0; i < 14; i++) begin
      if (i < 10) run_cycle(1, 1, 16'($urandom), 1, 0, 16'($urandom));
      else        run_cycle(0, 0, 16'h0, 0, 0, 16'h0);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL lockmax_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
      if (i < 9) begin
        checks++;
        if (o_r1 !== (i == 8)) begin errors++; $display("FAIL lockmax_grant i=%0d: req1_ready=%b, want %0d", i, o_r1, i == 8); end
      end
    end
  endtask

  task automatic test_err();
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       run_cycle(0, 0, 16'h0, 1, 0, 16'h0180);
        1:       run_cycle(0, 0, 16'h0, 1, 0, 16'h41A8);
        default: run_cycle(0, 0, 16'h0, 0, 0, 16'h0);
      endcase
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL err_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
      if (i == 3 || i == 4) begin
        checks++;
        if (o_v !== 1'b1 || o_id !== 1'b1 || o_err !== (i == 3) || o_data !== ((i == 3) ? 6'd0 : 6'd5)) begin
          errors++; $display("FAIL err_rsp i=%0d: valid=%b id=%b err=%b data=%0d", i, o_v, o_id, o_err, o_data);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset(1);
    run_cycle(1, 0, 16'h089D, 0, 0, 16'h0);
    checks++;
    if (obs_vec !== exp_vec) begin errors++; $display("FAIL midrst_accept cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
    do_reset(1);
    checks++;
    if (alsu_cmd !== 16'h0 || stat_issued !== 32'd0) begin
      errors++; $display("FAIL midrst_clear: alsu_cmd=%h stat_issued=%h, want 0", alsu_cmd, stat_issued);
    end
    for (int i = 0; i < 5; i++) begin
      run_cycle(0, 0, 16'h0, 0, 0, 16'h0);
      checks++;
      if (o_v !== 1'b0 || alsu_cmd !== 16'h0) begin
        errors++; $display("FAIL midrst_drop i=%0d: rsp_valid=%b alsu_cmd=%h, want 0", i, o_v, alsu_cmd);
      end
    end
  endtask

  task automatic test_random();
    do_reset(1);
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset(1);
      run_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 16'($urandom),
                $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 16'($urandom));
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL random_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
    end
    for (int i = 0; i < 4; i++) begin
      run_cycle(0, 0, 16'h0, 0, 0, 16'h0);
      checks++;
      if (obs_vec !== exp_vec) begin errors++; $display("FAIL random_drain cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_add();
    test_alternate();
    test_lock_chain();
    test_lock_max();
    test_err();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
